// File: rtl/csr_rmw_unit.sv
// Zicsr read-modify-write sequencer: takes one CSR instruction at a time, reads the
// addressed CSR, optionally writes the modified value back, and returns the old value.
module csr_rmw_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [2:0]  funct3_i,
  input  logic [11:0] csr_addr_i,
  input  logic [4:0]  rs1_idx_i,
  input  logic [31:0] rs1_data_i,
  output logic [31:0] csr_addr_o,
  output logic        csr_rd_o,
  output logic        csr_wr_o,
  output logic [31:0] csr_wdata_o,
  input  logic [31:0] csr_rdata_i,
  output logic        done_o,
  output logic        illegal_o,
  output logic [31:0] rd_data_o
);

  localparam int          NUM_RO   = 4;
  localparam logic [11:0] RO_FIRST = 12'hF11;
  localparam logic [11:0] RO_LAST  = RO_FIRST + 12'(NUM_RO - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  function automatic logic is_ro_addr(input logic [11:0] a);
    return (a >= RO_FIRST) && (a <= RO_LAST);
  endfunction

  function automatic logic is_known_addr(input logic [11:0] a);
    logic hit;
    case (a)
      12'h300, 12'h301, 12'h304, 12'h305, 12'h306,
      12'h341, 12'h342, 12'h344,
      12'hB00, 12'hB02, 12'hB80, 12'hB82: hit = 1'b1;
      default:                             hit = is_ro_addr(a);
    endcase
    return hit;
  endfunction

  // funct3 values 000 and 100 have no CSR operation encoded in the low bits
  function automatic logic is_legal_funct3(input logic [2:0] f);
    return f[1:0] != 2'b00;
  endfunction

  function automatic logic write_required(input logic [2:0] f, input logic [4:0] idx);
    return (f[1:0] == 2'b01) || (idx != 5'd0);
  endfunction

  state_e      state_q;
  logic        ready_q;
  logic        rd_q;
  logic        wr_q;
  logic        done_q;
  logic        illegal_q;
  logic [11:0] addr_q;
  logic [1:0]  op_q;
  logic [31:0] src_q;
  logic        wr_req_q;
  logic [31:0] wdata_q;
  logic [31:0] rd_data_q;

  logic [31:0] acc_src_s;
  logic        acc_wr_req_s;
  logic        acc_illegal_s;
  logic [31:0] wdata_d;

  // Decode of the instruction presented at the front, used only on accept
  always_comb begin
    acc_src_s     = funct3_i[2] ? {27'd0, rs1_idx_i} : rs1_data_i;
    acc_wr_req_s  = write_required(funct3_i, rs1_idx_i);
    acc_illegal_s = !is_legal_funct3(funct3_i) || !is_known_addr(csr_addr_i) ||
                    (acc_wr_req_s && is_ro_addr(csr_addr_i));
  end

  // New CSR value from the old value arriving from the CSR file during CAP
  always_comb begin
    wdata_d = src_q;
    case (op_q)
      2'b01:   wdata_d = src_q;
      2'b10:   wdata_d = csr_rdata_i | src_q;
      2'b11:   wdata_d = csr_rdata_i & ~src_q;
      default: wdata_d = src_q;
    endcase
  end

  // Transaction FSM; every strobe is a register set on the edge entering its state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b1;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      addr_q    <= 12'd0;
      op_q      <= 2'd0;
      src_q     <= 32'd0;
      wr_req_q  <= 1'b0;
      wdata_q   <= 32'd0;
      rd_data_q <= 32'd0;
    end else begin
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (valid_i) begin
            addr_q   <= csr_addr_i;
            op_q     <= funct3_i[1:0];
            src_q    <= acc_src_s;
            wr_req_q <= acc_wr_req_s;
            ready_q  <= 1'b0;
            if (acc_illegal_s) begin
              state_q   <= ST_DONE;
              done_q    <= 1'b1;
              illegal_q <= 1'b1;
              rd_data_q <= 32'd0;
            end else begin
              state_q <= ST_RD;
              rd_q    <= 1'b1;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_RD: begin
          state_q <= ST_CAP;
        end
        ST_CAP: begin
          rd_data_q <= csr_rdata_i;
          wdata_q   <= wdata_d;
          if (wr_req_q) begin
            state_q <= ST_WR;
            wr_q    <= 1'b1;
          end else begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_WR: begin
          state_q <= ST_DONE;
          done_q  <= 1'b1;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o     = ready_q;
  assign csr_rd_o    = rd_q;
  assign csr_wr_o    = wr_q;
  assign done_o      = done_q;
  assign illegal_o   = illegal_q;
  assign csr_addr_o  = {20'd0, addr_q};
  assign csr_wdata_o = wdata_q;
  assign rd_data_o   = rd_data_q;

endmodule

// File: tb/tb_csr_rmw_unit.sv
// Directed bench for csr_rmw_unit with a small behavioural CSR file behind it.
module tb_csr_rmw_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [2:0]  funct3_i;
  logic [11:0] csr_addr_i;
  logic [4:0]  rs1_idx_i;
  logic [31:0] rs1_data_i;
  logic [31:0] csr_addr_o;
  logic        csr_rd_o;
  logic        csr_wr_o;
  logic [31:0] csr_wdata_o;
  logic [31:0] csr_rdata_i;
  logic        done_o;
  logic        illegal_o;
  logic [31:0] rd_data_o;

  csr_rmw_unit dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .funct3_i    (funct3_i),
    .csr_addr_i  (csr_addr_i),
    .rs1_idx_i   (rs1_idx_i),
    .rs1_data_i  (rs1_data_i),
    .csr_addr_o  (csr_addr_o),
    .csr_rd_o    (csr_rd_o),
    .csr_wr_o    (csr_wr_o),
    .csr_wdata_o (csr_wdata_o),
    .csr_rdata_i (csr_rdata_i),
    .done_o      (done_o),
    .illegal_o   (illegal_o),
    .rd_data_o   (rd_data_o)
  );

  always #5 clk_i = ~clk_i;

  // CSR file: registered read port, write on the strobe edge, plus a preload port
  logic [31:0] csr_mem [0:4095];
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = 12'd0;
  logic [31:0] pl_data = 32'd0;

  always @(posedge clk_i) begin
    if (pl_en) csr_mem[pl_addr] <= pl_data;
    if (csr_wr_o) csr_mem[csr_addr_o[11:0]] <= csr_wdata_o;
    if (csr_rd_o) csr_rdata_i <= csr_mem[csr_addr_o[11:0]];
  end

  // Strobe counters sampled on each edge
  int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, both_cnt = 0;
  always @(posedge clk_i) begin
    if (csr_rd_o) rd_cnt <= rd_cnt + 1;
    if (csr_wr_o) wr_cnt <= wr_cnt + 1;
    if (done_o) done_cnt <= done_cnt + 1;
    if (csr_rd_o && csr_wr_o) both_cnt <= both_cnt + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  int          r_rd, r_wr, r_done;
  logic [31:0] r_waddr, r_wdata, r_rdv, r_addr_hi;
  logic        r_ill;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk_i); #1;
    pl_en = 1'b0;
  endtask

  // Issues one instruction from IDLE and records when each event appears (cycle 1 = after accept)
  task automatic run_op(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] idx,
                        input logic [31:0] data);
    r_rd = -1; r_wr = -1; r_done = -1;
    r_waddr = 32'd0; r_wdata = 32'd0; r_rdv = 32'hBAD0_BAD0; r_ill = 1'bx; r_addr_hi = 32'd0;
    funct3_i = f3; csr_addr_i = addr; rs1_idx_i = idx; rs1_data_i = data; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0; funct3_i = 3'b000; csr_addr_i = 12'hFFF; rs1_idx_i = 5'd31;
    rs1_data_i = 32'hFFFF_FFFF;
    for (int k = 1; k <= 8; k++) begin
      r_addr_hi = r_addr_hi | {12'd0, csr_addr_o[31:12]};
      if (csr_rd_o && r_rd < 0) r_rd = k;
      if (csr_wr_o) begin
        r_wr = k; r_waddr = csr_addr_o; r_wdata = csr_wdata_o;
      end
      if (done_o) begin
        r_done = k; r_rdv = rd_data_o; r_ill = illegal_o;
        break;
      end
      @(posedge clk_i); #1;
    end
    @(posedge clk_i); #1;
  endtask

  task automatic expect_op(input string tag, input int e_rd, input int e_wr, input int e_done,
                           input logic [31:0] e_waddr, input logic [31:0] e_wdata,
                           input logic [31:0] e_rdv, input logic e_ill);
    check({tag, ".rd_cyc"}, r_rd, e_rd);
    check({tag, ".wr_cyc"}, r_wr, e_wr);
    check({tag, ".done_cyc"}, r_done, e_done);
    if (e_wr >= 0) begin
      check({tag, ".wr_addr"}, r_waddr, e_waddr);
      check({tag, ".wr_data"}, r_wdata, e_wdata);
    end
    check({tag, ".rd_data"}, r_rdv, e_rdv);
    check({tag, ".illegal"}, {31'd0, r_ill}, {31'd0, e_ill});
    check({tag, ".addr_hi"}, r_addr_hi, 32'd0);
    check({tag, ".ready"}, {31'd0, ready_o}, 32'd1);
  endtask

  int          rd0, wr0, dn0;
  int          rd1, rd2, dn1, dn2;
  logic [31:0] rv2;

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; funct3_i = 3'b000; csr_addr_i = 12'd0;
    rs1_idx_i = 5'd0; rs1_data_i = 32'd0;
    preload(12'h305, 32'h0000_0000);
    preload(12'h300, 32'h0000_0088);
    preload(12'hF14, 32'hDEAD_BEEF);
    preload(12'h341, 32'h1234_5678);
    preload(12'h304, 32'h0000_0000);
    preload(12'hF11, 32'h0000_0011);

    check("rst.ready", {31'd0, ready_o}, 32'd1);
    check("rst.strobes", {28'd0, csr_rd_o, csr_wr_o, done_o, illegal_o}, 32'd0);
    check("rst.addr", csr_addr_o, 32'd0);
    check("rst.wdata", csr_wdata_o, 32'd0);
    check("rst.rd_data", rd_data_o, 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    run_op(3'b001, 12'h305, 5'd9, 32'h0000_1000);
    expect_op("csrrw_305", 1, 3, 4, 32'h305, 32'h1000, 32'h0, 1'b0);
    run_op(3'b010, 12'h305, 5'd0, 32'h0000_FFFF);
    expect_op("csrrs_305_x0", 1, -1, 3, 32'h0, 32'h0, 32'h1000, 1'b0);
    run_op(3'b110, 12'h300, 5'd5, 32'hFFFF_0000);
    expect_op("csrrsi_300", 1, 3, 4, 32'h300, 32'h8D, 32'h88, 1'b0);
    run_op(3'b011, 12'h300, 5'd2, 32'h0000_0008);
    expect_op("csrrc_300", 1, 3, 4, 32'h300, 32'h85, 32'h8D, 1'b0);
    check("addr_hold_idle", csr_addr_o, 32'h300);

    rd0 = rd_cnt; wr0 = wr_cnt;
    run_op(3'b100, 12'h300, 5'd1, 32'h0000_0001);
    expect_op("ill_funct3_100", -1, -1, 1, 32'h0, 32'h0, 32'h0, 1'b1);
    run_op(3'b010, 12'h7C0, 5'd0, 32'h0);
    expect_op("ill_addr_7c0", -1, -1, 1, 32'h0, 32'h0, 32'h0, 1'b1);
    run_op(3'b001, 12'hF11, 5'd3, 32'h0000_0055);
    expect_op("ill_rw_f11", -1, -1, 1, 32'h0, 32'h0, 32'h0, 1'b1);
    run_op(3'b110, 12'hF13, 5'd1, 32'h0);
    expect_op("ill_rsi_f13", -1, -1, 1, 32'h0, 32'h0, 32'h0, 1'b1);
    run_op(3'b000, 12'h300, 5'd0, 32'h0);
    expect_op("ill_funct3_000", -1, -1, 1, 32'h0, 32'h0, 32'h0, 1'b1);
    check("ill.no_rd", rd_cnt, rd0);
    check("ill.no_wr", wr_cnt, wr0);
    check("ill.f11_kept", csr_mem[12'hF11], 32'h11);

    run_op(3'b010, 12'hF14, 5'd0, 32'h0000_00FF);
    expect_op("ro_read_f14", 1, -1, 3, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // Reset asserted mid-cycle while the unit is in CAP of a CSRRW
    wr0 = wr_cnt; dn0 = done_cnt;
    funct3_i = 3'b001; csr_addr_i = 12'h341; rs1_idx_i = 5'd4; rs1_data_i = 32'h5555_AAAA;
    valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    check("rstmid.rd_in_rd", {31'd0, csr_rd_o}, 32'd1);
    @(posedge clk_i); #1;
    check("rstmid.cap_quiet", {30'd0, csr_rd_o, csr_wr_o}, 32'd0);
    #2 rst_i = 1'b1;
    #1;
    check("rstmid.ready_now", {31'd0, ready_o}, 32'd1);
    check("rstmid.strobes_now", {29'd0, csr_wr_o, done_o, illegal_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    check("rstmid.no_wr", wr_cnt, wr0);
    check("rstmid.no_done", done_cnt, dn0);
    check("rstmid.341_kept", csr_mem[12'h341], 32'h1234_5678);
    check("rstmid.ready_after", {31'd0, ready_o}, 32'd1);

    // Back-to-back CSRRWI to 0x304 with valid held high across DONE
    rd1 = -1; rd2 = -1; dn1 = -1; dn2 = -1; rv2 = 32'hBAD0_BAD0;
    funct3_i = 3'b101; csr_addr_i = 12'h304; rs1_idx_i = 5'd3; rs1_data_i = 32'h0;
    valid_i = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk_i); #1;
      if (k == 1) rs1_idx_i = 5'd7;
      if (k == 6) valid_i = 1'b0;
      if (csr_rd_o) begin
        if (rd1 < 0) rd1 = k;
        else if (rd2 < 0) rd2 = k;
      end
      if (done_o) begin
        if (dn1 < 0) dn1 = k;
        else if (dn2 < 0) begin
          dn2 = k; rv2 = rd_data_o;
        end
      end
    end
    check("b2b.rd1", rd1, 32'd1);
    check("b2b.done1", dn1, 32'd4);
    check("b2b.rd2", rd2, 32'd6);
    check("b2b.done2", dn2, 32'd9);
    check("b2b.rd_data2", rv2, 32'd3);
    check("b2b.final_304", csr_mem[12'h304], 32'd7);
    check("final_300", csr_mem[12'h300], 32'h85);
    check("never_rd_and_wr", both_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
